// File: rtl/btn_ctrl_pkg.sv
// Shared constants and width helpers for the multi-channel button controller.
package btn_ctrl_pkg;

  localparam int DEB_CNT_DEFAULT  = 1048575;
  localparam int LONG_CNT_DEFAULT = 50000000;
  localparam int SYNC_STAGES_MIN  = 2;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter width able to hold 0..terminal-1, never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (clog2(terminal) < 1) ? 1 : clog2(terminal);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stable-run debounce counter, debounced level
// and registered rise/fall pulses.
module btn_debounce_ch
  import btn_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int DEB_CNT     = DEB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_lvl,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int DEB_N  = (DEB_CNT < 1) ? 1 : DEB_CNT;
  localparam int DEB_W  = cnt_width(DEB_N);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);

  logic [SYNC_N-1:0] r_sync;
  logic [DEB_W-1:0]  r_cnt;
  logic              r_lvl;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;
  logic              w_diff;
  logic              w_accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], btn_in};
    end
  end

  assign w_s      = r_sync[SYNC_N-1];
  assign w_diff   = w_s ^ r_lvl;
  assign w_accept = w_diff && (r_cnt == DEB_LAST);

  // Any sample matching the current level restarts the stable-run count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept & w_s;
      r_fall <= w_accept & ~w_s;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_lvl <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign btn_lvl  = r_lvl;
  assign btn_rise = r_rise;
  assign btn_fall = r_fall;

endmodule

// File: rtl/btn_ctrl_multi.sv
// N-channel button controller: debounced levels, edge pulses and wrapping select counters.
// Define LONG_PRESS_EN to add per-channel long-press detection (count on release instead).
module btn_ctrl_multi
  import btn_ctrl_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = DEB_CNT_DEFAULT,
  parameter int CNT_W       = 2,
  parameter int CNT_MAX     = 3,
  parameter int LONG_CNT    = LONG_CNT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       btn_in,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       btn_lvl,
  output logic [N_CH-1:0]       btn_rise,
  output logic [N_CH-1:0]       btn_fall,
  output logic [N_CH*CNT_W-1:0] sel_cnt,
  output logic [N_CH-1:0]       long_pulse
);

  localparam logic [CNT_W-1:0] SEL_LAST = CNT_W'(CNT_MAX);

  if (N_CH < 1 || CNT_MAX < 0 || CNT_MAX > (1 << CNT_W) - 1 || LONG_CNT < 1) begin : g_param_err
    $error("btn_ctrl_multi: illegal parameter combination");
  end

`ifdef LONG_PRESS_EN
  localparam int LONG_N = (LONG_CNT < 1) ? 1 : LONG_CNT;
  localparam int HOLD_W = cnt_width(LONG_N);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_N - 1);
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_sel;
    logic             w_step;
    logic             w_zero;

    btn_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT     (DEB_CNT)
    ) u_deb (
      .clk      (clk),
      .rstn     (rstn),
      .btn_in   (btn_in[gi]),
      .btn_lvl  (btn_lvl[gi]),
      .btn_rise (btn_rise[gi]),
      .btn_fall (btn_fall[gi])
    );

`ifdef LONG_PRESS_EN
    logic [HOLD_W-1:0] r_hold;
    logic              r_long;
    logic              r_lp;
    logic              w_fire;

    // The hold count freezes once the press is marked long, so it fires only once.
    assign w_fire = btn_lvl[gi] && !r_long && (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_hold <= '0;
        r_long <= 1'b0;
        r_lp   <= 1'b0;
      end else begin
        r_lp <= w_fire;
        if (btn_fall[gi]) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else if (w_fire) begin
          r_long <= 1'b1;
        end else if (btn_lvl[gi] && !r_long) begin
          r_hold <= r_hold + HOLD_W'(1);
        end
      end
    end

    assign w_step         = btn_fall[gi] && !r_long;
    assign w_zero         = clr[gi] || w_fire;
    assign long_pulse[gi] = r_lp;
`else
    assign w_step         = btn_rise[gi];
    assign w_zero         = clr[gi];
    assign long_pulse[gi] = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_sel <= '0;
      end else if (w_zero) begin
        r_sel <= '0;
      end else if (w_step) begin
        r_sel <= (r_sel >= SEL_LAST) ? '0 : r_sel + CNT_W'(1);
      end
    end

    assign sel_cnt[gi*CNT_W +: CNT_W] = r_sel;
  end

endmodule

// File: tb/tb_btn_ctrl_multi.sv
// Randomised and directed bench for btn_ctrl_multi against a stable-run reference model.
module tb_btn_ctrl_multi;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int CW   = 2;
  localparam int CMAX = 2;
  localparam int LONG = 32;
  localparam int VW   = N_CH * 4 + N_CH * CW;

  logic                 clk  = 1'b0;
  logic                 rstn = 1'b0;
  logic [N_CH-1:0]      btn_in = '0;
  logic [N_CH-1:0]      clr = '0;
  logic [N_CH-1:0]      btn_lvl;
  logic [N_CH-1:0]      btn_rise;
  logic [N_CH-1:0]      btn_fall;
  logic [N_CH*CW-1:0]   sel_cnt;
  logic [N_CH-1:0]      long_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_ctrl_multi #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .DEB_CNT     (DEB),
    .CNT_W       (CW),
    .CNT_MAX     (CMAX),
    .LONG_CNT    (LONG)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_in     (btn_in),
    .clr        (clr),
    .btn_lvl    (btn_lvl),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .sel_cnt    (sel_cnt),
    .long_pulse (long_pulse)
  );

  // Reference model: input seen SYNC edges late; level flips after DEB consecutive
  // differing samples; presses counted in held cycles.
  logic [N_CH-1:0] m_hist [SYNC];
  logic [N_CH-1:0] m_lvl, m_rise, m_fall, m_lp;
  int m_run [N_CH];
  int m_sel [N_CH];
`ifdef LONG_PRESS_EN
  int m_held [N_CH];
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_lp = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_run[c] = 0;
        m_sel[c] = 0;
`ifdef LONG_PRESS_EN
        m_held[c] = 0;
`endif
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        logic s, fire, step;
        s    = m_hist[SYNC-1][c];
        fire = 1'b0;
        step = m_rise[c];
`ifdef LONG_PRESS_EN
        step = 1'b0;
        if (m_fall[c]) begin
          step = (m_held[c] < LONG);
          m_held[c] = 0;
        end else if (m_lvl[c]) begin
          m_held[c] = m_held[c] + 1;
          fire = (m_held[c] == LONG);
        end
`endif
        m_lp[c] = fire;
        if (clr[c] || fire) m_sel[c] = 0;
        else if (step) m_sel[c] = (m_sel[c] == CMAX) ? 0 : m_sel[c] + 1;
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (s != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DEB) begin
            m_lvl[c]  = s;
            m_rise[c] = s;
            m_fall[c] = ~s;
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        for (int k = SYNC - 1; k > 0; k--) m_hist[k][c] = m_hist[k-1][c];
        m_hist[0][c] = btn_in[c];
      end
    end
  end

  function automatic logic [VW-1:0] vec_dut();
    return {btn_lvl, btn_rise, btn_fall, sel_cnt, long_pulse};
  endfunction

  function automatic logic [VW-1:0] vec_mdl();
    logic [N_CH*CW-1:0] sv;
    for (int c = 0; c < N_CH; c++) sv[c*CW +: CW] = CW'(m_sel[c]);
    return {m_lvl, m_rise, m_fall, sv, m_lp};
  endfunction

  function automatic logic [CW-1:0] sel_of(input int c);
    return sel_cnt[c*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_in = 4'hF;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (vec_dut() !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%h required=0", vec_dut());
    end
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (btn_lvl !== ((k >= 10) ? 4'hF : 4'h0) || btn_rise !== ((k == 10) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("FAIL reset_latency k=%0d: lvl=%h rise=%h", k, btn_lvl, btn_rise);
      end
      n_checks++;
      if (vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL reset_model k=%0d: dut=%h model=%h", k, vec_dut(), vec_mdl());
      end
    end
    btn_in = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: dut=%h model=%h", k, vec_dut(), vec_mdl());
      end
    end
    clr = '1;
    tick();
    clr = '0;
    $display("reset: held buttons accepted after release, levels=%h", btn_lvl);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) btn_in[0] = ~btn_in[0];
      tick();
      n_checks++;
      if (btn_rise[0] !== 1'b0 || btn_fall[0] !== 1'b0 || vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL bounce_quiet k=%0d: dut=%h model=%h", k, vec_dut(), vec_mdl());
      end
    end
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (btn_rise[0] !== (k == 10) || vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL bounce_settle k=%0d: rise0=%b dut=%h model=%h", k, btn_rise[0], vec_dut(), vec_mdl());
      end
    end
    btn_in[0] = 1'b0;
    repeat (14) tick();
    clr = '1;
    tick();
    clr = '0;
    $display("bounce: single accepted press after bouncing on ch0");
  endtask

  task automatic test_wrap();
    int exp_seq [4] = '{1, 2, 0, 1};
    for (int p = 0; p < 4; p++) begin
      btn_in[1] = 1'b1;
      for (int k = 0; k < 14; k++) begin
        tick();
        n_checks++;
        if (vec_dut() !== vec_mdl()) begin
          n_fail++;
          $display("FAIL wrap_press p=%0d k=%0d: dut=%h model=%h", p, k, vec_dut(), vec_mdl());
        end
      end
      btn_in[1] = 1'b0;
      for (int k = 0; k < 14; k++) begin
        tick();
        n_checks++;
        if (vec_dut() !== vec_mdl()) begin
          n_fail++;
          $display("FAIL wrap_release p=%0d k=%0d: dut=%h model=%h", p, k, vec_dut(), vec_mdl());
        end
      end
      n_checks++;
      if (sel_of(1) !== CW'(exp_seq[p]) || sel_of(0) !== '0 || sel_of(2) !== '0 || sel_of(3) !== '0) begin
        n_fail++;
        $display("FAIL wrap_seq p=%0d: sel_cnt=%h required ch1=%0d others 0", p, sel_cnt, exp_seq[p]);
      end
      $display("wrap: press %0d on ch1 -> sel_cnt=%h", p, sel_cnt);
    end
  endtask

  task automatic test_clr_collision();
    // first press so the counter is non-zero before the collision
    btn_in[2] = 1'b1;
    repeat (14) tick();
    btn_in[2] = 1'b0;
    repeat (14) tick();
    btn_in[2] = 1'b1;
`ifdef LONG_PRESS_EN
    repeat (14) tick();
    btn_in[2] = 1'b0;
`endif
    repeat (10) tick();
    n_checks++;
`ifdef LONG_PRESS_EN
    if (btn_fall[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_event: fall2=%b required=1", btn_fall[2]);
    end
`else
    if (btn_rise[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_event: rise2=%b required=1", btn_rise[2]);
    end
`endif
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    n_checks++;
    if (sel_of(2) !== '0 || vec_dut() !== vec_mdl()) begin
      n_fail++;
      $display("FAIL clr_priority: sel2=%0d required=0 dut=%h model=%h", sel_of(2), vec_dut(), vec_mdl());
    end
    btn_in[2] = 1'b0;
    repeat (14) tick();
    clr = '1;
    tick();
    clr = '0;
    $display("clr: clear beats simultaneous increment on ch2");
  endtask

  task automatic test_simultaneous();
    btn_in = 4'b1001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (btn_rise !== ((k == 10) ? 4'b1001 : 4'b0000) || vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL simul_rise k=%0d: rise=%h dut=%h model=%h", k, btn_rise, vec_dut(), vec_mdl());
      end
    end
    btn_in = '0;
    repeat (14) tick();
    n_checks++;
    if (sel_of(0) !== CW'(1) || sel_of(3) !== CW'(1) || sel_of(1) !== '0 || sel_of(2) !== '0) begin
      n_fail++;
      $display("FAIL simul_count: sel_cnt=%h required ch0=1 ch3=1", sel_cnt);
    end
    $display("simultaneous: ch0+ch3 -> sel_cnt=%h", sel_cnt);
    clr = '1;
    tick();
    clr = '0;
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long();
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      n_checks++;
      if (long_pulse[0] !== (k == 42) || vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL long_pulse k=%0d: lp0=%b dut=%h model=%h", k, long_pulse[0], vec_dut(), vec_mdl());
      end
    end
    btn_in[0] = 1'b0;
    repeat (14) tick();
    n_checks++;
    if (sel_of(0) !== '0) begin
      n_fail++;
      $display("FAIL long_no_inc: sel0=%0d required=0", sel_of(0));
    end
    btn_in[0] = 1'b1;
    repeat (15) tick();
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (sel_of(0) !== ((k >= 11) ? CW'(1) : CW'(0)) || vec_dut() !== vec_mdl()) begin
        n_fail++;
        $display("FAIL short_inc k=%0d: sel0=%0d dut=%h model=%h", k, sel_of(0), vec_dut(), vec_mdl());
      end
    end
    $display("long: long press cleared ch0, short press counted sel0=%0d", sel_of(0));
  endtask
`endif

  task automatic test_random();
    int cd [N_CH];
    int bad = 0;
    for (int c = 0; c < N_CH; c++) cd[c] = $urandom_range(1, 60);
    for (int k = 0; k < 2500; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        cd[c] = cd[c] - 1;
        if (cd[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          cd[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 60);
        end
        clr[c] = ($urandom_range(0, 63) == 0);
      end
      tick();
      n_checks++;
      if (vec_dut() !== vec_mdl()) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random k=%0d: dut=%h model=%h", k, vec_dut(), vec_mdl());
      end
    end
    clr = '0;
    $display("random: 2500 cycles compared, %0d differences", bad);
  endtask

  initial begin
    rstn   = 1'b0;
    btn_in = '0;
    clr    = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_bounce();
    test_wrap();
    test_clr_collision();
    test_simultaneous();
`ifdef LONG_PRESS_EN
    test_long();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
